// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 control sequencer (IDLE/FETCH/DECODE/EXEC/WB).
// Define MULTICYCLE_CTRL_MUL_EN to build the iterative-multiplier path (MUL_WAIT, start/done, timeout).
module multicycle_ctrl #(
  parameter int MUL_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [6:0]       op_code_i,
  input  logic [6:0]       funct7_i,
  input  logic             imem_ready_i,
  input  logic             mul_done_i,
  output logic             imem_req_o,
  output logic             ir_we_o,
  output logic [1:0]       aluop_o,
  output logic             alusrc_o,
  output logic             mul_start_o,
  output logic             reg_we_o,
  output logic             pc_we_o,
  output logic             busy_o,
  output logic             illegal_o,
  output logic             mul_err_o,
  output logic [CNT_W-1:0] retired_o
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] F7_MUL = 7'b0000001;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    DECODE   = 3'd2,
    EXEC     = 3'd3,
    WB       = 3'd4
`ifdef MULTICYCLE_CTRL_MUL_EN
    ,
    MUL_WAIT = 3'd5
`endif
  } state_t;

  state_t     state;
  logic [1:0] aluop_q;
  logic       alusrc_q;
  logic       illegal_q;
  logic       dec_r;
  logic       dec_i;
  logic [1:0] dec_aluop;
  logic       dec_alusrc;

  // IR is only guaranteed valid from DECODE on, so the class is decoded live there and held afterwards.
  assign dec_r      = (op_code_i == OP_R);
  assign dec_i      = (op_code_i == OP_I);
  assign dec_aluop  = dec_r ? 2'b10 : 2'b00;
  assign dec_alusrc = dec_i;
  assign ir_we_o    = (state == FETCH) && imem_ready_i;

`ifdef MULTICYCLE_CTRL_MUL_EN
  localparam int MCW = (MUL_TIMEOUT > 2) ? $clog2(MUL_TIMEOUT) : 1;
  localparam logic [MCW-1:0] MUL_LAST = MCW'(MUL_TIMEOUT - 1);

  logic [MCW-1:0] mul_cnt;
  logic           dec_mul;

  assign dec_mul     = dec_r && (funct7_i == F7_MUL);
  assign mul_start_o = (state == DECODE) && dec_mul;
`else
  logic unused_mul_inputs;

  assign unused_mul_inputs = ^{mul_done_i, funct7_i};
  assign mul_start_o       = 1'b0;
  assign mul_err_o         = 1'b0;
`endif

  always_comb begin
    aluop_o  = 2'b00;
    alusrc_o = 1'b0;
    case (state)
      IDLE, FETCH: begin
        aluop_o  = 2'b00;
        alusrc_o = 1'b0;
      end
      DECODE: begin
        aluop_o  = dec_aluop;
        alusrc_o = dec_alusrc;
      end
      default: begin
        aluop_o  = aluop_q;
        alusrc_o = alusrc_q;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      busy_o     <= 1'b0;
      imem_req_o <= 1'b0;
      reg_we_o   <= 1'b0;
      pc_we_o    <= 1'b0;
      illegal_o  <= 1'b0;
      aluop_q    <= 2'b00;
      alusrc_q   <= 1'b0;
      illegal_q  <= 1'b0;
      retired_o  <= '0;
`ifdef MULTICYCLE_CTRL_MUL_EN
      mul_cnt    <= '0;
      mul_err_o  <= 1'b0;
`endif
    end else begin
      reg_we_o  <= 1'b0;
      pc_we_o   <= 1'b0;
      illegal_o <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_i) begin
            state      <= FETCH;
            busy_o     <= 1'b1;
            imem_req_o <= 1'b1;
          end
        end
        FETCH: begin
          if (imem_ready_i) begin
            state      <= DECODE;
            imem_req_o <= 1'b0;
          end
        end
        DECODE: begin
          aluop_q   <= dec_aluop;
          alusrc_q  <= dec_alusrc;
          illegal_q <= !(dec_r || dec_i);
`ifdef MULTICYCLE_CTRL_MUL_EN
          mul_cnt   <= '0;
          if (dec_mul) begin
            state <= MUL_WAIT;
          end else begin
            state <= EXEC;
          end
`else
          state     <= EXEC;
`endif
        end
        EXEC: begin
          state     <= WB;
          pc_we_o   <= 1'b1;
          reg_we_o  <= !illegal_q;
          illegal_o <= illegal_q;
        end
`ifdef MULTICYCLE_CTRL_MUL_EN
        // A done arriving in the last allowed cycle still counts as a normal completion.
        MUL_WAIT: begin
          if (mul_done_i) begin
            state    <= WB;
            pc_we_o  <= 1'b1;
            reg_we_o <= 1'b1;
          end else if (mul_cnt == MUL_LAST) begin
            state     <= WB;
            pc_we_o   <= 1'b1;
            mul_err_o <= 1'b1;
          end else begin
            mul_cnt <= mul_cnt + MCW'(1);
          end
        end
`endif
        WB: begin
          retired_o <= retired_o + CNT_W'(1);
          if (enable_i) begin
            state      <= FETCH;
            imem_req_o <= 1'b1;
          end else begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver queues per-instruction expectations,
// the monitor pops and compares them at every write-back (pc_we_o) cycle.
module tb_multicycle_ctrl;

  localparam int TIMEOUT = 8;
  localparam int CW      = 4;
`ifdef MULTICYCLE_CTRL_MUL_EN
  localparam bit MUL_BUILD = 1'b1;
`else
  localparam bit MUL_BUILD = 1'b0;
`endif
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_B = 7'b1100011;

  logic          clk;
  logic          rst_i;
  logic          enable_i;
  logic [6:0]    op_code_i;
  logic [6:0]    funct7_i;
  logic          imem_ready_i;
  logic          mul_done_i;
  logic          imem_req_o;
  logic          ir_we_o;
  logic [1:0]    aluop_o;
  logic          alusrc_o;
  logic          mul_start_o;
  logic          reg_we_o;
  logic          pc_we_o;
  logic          busy_o;
  logic          illegal_o;
  logic          mul_err_o;
  logic [CW-1:0] retired_o;

  multicycle_ctrl #(
    .MUL_TIMEOUT(TIMEOUT),
    .CNT_W      (CW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .enable_i    (enable_i),
    .op_code_i   (op_code_i),
    .funct7_i    (funct7_i),
    .imem_ready_i(imem_ready_i),
    .mul_done_i  (mul_done_i),
    .imem_req_o  (imem_req_o),
    .ir_we_o     (ir_we_o),
    .aluop_o     (aluop_o),
    .alusrc_o    (alusrc_o),
    .mul_start_o (mul_start_o),
    .reg_we_o    (reg_we_o),
    .pc_we_o     (pc_we_o),
    .busy_o      (busy_o),
    .illegal_o   (illegal_o),
    .mul_err_o   (mul_err_o),
    .retired_o   (retired_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         cycles;
    int         reqs;
    int         irw;
    int         mst;
    int         regw;
    int         ill;
    logic [1:0] aluop;
    logic       alusrc;
    logic       merr;
    logic [CW-1:0] ret;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [CW-1:0] ret_model;
  bit            err_model;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one instruction from FETCH to WB and queues what the monitor must see for it.
  task automatic applyStimulus(input string name, input logic [6:0] op, input logic [6:0] f7,
                               input int wait_n, input int mul_k, input bit en_after);
    exp_t e;
    bit   is_r, is_i, ill, is_mul, tmo;
    int   kk, guard;
    is_r   = (op == OP_R);
    is_i   = (op == OP_I);
    ill    = !(is_r || is_i);
    is_mul = MUL_BUILD && is_r && (f7 == 7'b0000001);
    tmo    = is_mul && (mul_k == 0);
    kk     = is_mul ? (tmo ? TIMEOUT : mul_k) : 1;
    if (tmo) err_model = 1'b1;
    e.name   = name;
    e.cycles = (wait_n + 1) + 1 + kk + 1;
    e.reqs   = wait_n + 1;
    e.irw    = 1;
    e.mst    = is_mul ? 1 : 0;
    e.regw   = (!ill && !tmo) ? 1 : 0;
    e.ill    = ill ? 1 : 0;
    e.aluop  = is_r ? 2'b10 : 2'b00;
    e.alusrc = is_i;
    e.merr   = err_model;
    e.ret    = ret_model;
    ret_model = ret_model + 1'b1;
    sb.push_back(e);

    guard = 0;
    while (!imem_req_o && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) begin
      checkOutput({name, "_reached_fetch"}, int'(imem_req_o), 1);
      return;
    end
    imem_ready_i = 1'b0;
    repeat (wait_n) tick();
    op_code_i    = op;
    funct7_i     = f7;
    imem_ready_i = 1'b1;
    tick();
    imem_ready_i = 1'b0;
    if (!en_after) enable_i = 1'b0;
`ifdef MULTICYCLE_CTRL_MUL_EN
    if (is_mul && mul_k > 0) begin
      tick();
      repeat (mul_k - 1) tick();
      mul_done_i = 1'b1;
      tick();
      mul_done_i = 1'b0;
    end
`endif
    guard = 0;
    while (!pc_we_o && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) checkOutput({name, "_reached_wb"}, int'(pc_we_o), 1);
  endtask

  // Monitor: accumulates per-instruction strobe counts and scores them at write-back.
  initial begin
    int   cyc, rq, iw, ms, rw, il;
    exp_t e;
    cyc = 0; rq = 0; iw = 0; ms = 0; rw = 0; il = 0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        cyc = 0; rq = 0; iw = 0; ms = 0; rw = 0; il = 0;
      end else begin
        if (busy_o)      cyc++;
        if (imem_req_o)  rq++;
        if (ir_we_o)     iw++;
        if (mul_start_o) ms++;
        if (reg_we_o)    rw++;
        if (illegal_o)   il++;
        if (pc_we_o) begin
          checkOutput("wb_has_expectation", int'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput({e.name, "_cycles"},    cyc, e.cycles);
            checkOutput({e.name, "_imem_req"},  rq,  e.reqs);
            checkOutput({e.name, "_ir_we"},     iw,  e.irw);
            checkOutput({e.name, "_mul_start"}, ms,  e.mst);
            checkOutput({e.name, "_reg_we"},    rw,  e.regw);
            checkOutput({e.name, "_illegal"},   il,  e.ill);
            checkOutput({e.name, "_aluop"},     int'(aluop_o),   int'(e.aluop));
            checkOutput({e.name, "_alusrc"},    int'(alusrc_o),  int'(e.alusrc));
            checkOutput({e.name, "_mul_err"},   int'(mul_err_o), int'(e.merr));
            checkOutput({e.name, "_retired"},   int'(retired_o), int'(e.ret));
          end
          cyc = 0; rq = 0; iw = 0; ms = 0; rw = 0; il = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i        = 1'b1;
    enable_i     = 1'b0;
    imem_ready_i = 1'b0;
    mul_done_i   = 1'b0;
    op_code_i    = 7'd0;
    funct7_i     = 7'd0;
    ret_model    = '0;
    err_model    = 1'b0;
    repeat (3) tick();
    checkOutput("reset_outputs", int'({busy_o, imem_req_o, ir_we_o, aluop_o, alusrc_o, mul_start_o,
                                       reg_we_o, pc_we_o, illegal_o, mul_err_o}), 0);
    checkOutput("reset_retired", int'(retired_o), 0);
    rst_i = 1'b0;

    mul_done_i = 1'b1;
    tick();
    mul_done_i = 1'b0;
    tick();
    checkOutput("idle_done_busy", int'(busy_o), 0);
    checkOutput("idle_done_err", int'(mul_err_o), 0);

    enable_i = 1'b1;
    applyStimulus("r_add", OP_R, 7'h00, 0, 0, 1'b1);
    tick();
    checkOutput("retired_after_first", int'(retired_o), 1);
    checkOutput("b2b_fetch", int'(imem_req_o), 1);
    applyStimulus("i_addi_wait3", OP_I, 7'h00, 3, 0, 1'b1);
    applyStimulus("mul_k5", OP_R, 7'h01, 0, 5, 1'b1);
    applyStimulus("mul_timeout", OP_R, 7'h01, 0, 0, 1'b1);
    applyStimulus("illegal_branch", OP_B, 7'h00, 0, 0, 1'b1);
    applyStimulus("mul_k1", OP_R, 7'h01, 0, 1, 1'b1);
    applyStimulus("mul_done_last", OP_R, 7'h01, 0, TIMEOUT, 1'b1);
    for (int i = 0; i < 9; i++) begin
      applyStimulus($sformatf("fill%0d", i), (i % 2 == 1) ? OP_I : OP_R,
                    (i % 2 == 1) ? 7'h00 : 7'h20, i % 2, 0, i != 8);
    end
    tick();
    checkOutput("retired_wrap", int'(retired_o), 0);
    checkOutput("drop_enable_busy", int'(busy_o), 0);
    tick();
    checkOutput("idle_no_req", int'(imem_req_o), 0);

    enable_i = 1'b1;
    applyStimulus("r_after_idle", OP_R, 7'h00, 0, 0, 1'b1);
    tick();
    op_code_i    = OP_R;
    funct7_i     = 7'h00;
    imem_ready_i = 1'b1;
    tick();
    imem_ready_i = 1'b0;
    tick();
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("rst_exec_outputs", int'({busy_o, imem_req_o, ir_we_o, aluop_o, alusrc_o, mul_start_o,
                                          reg_we_o, pc_we_o, illegal_o, mul_err_o}), 0);
    checkOutput("rst_exec_retired", int'(retired_o), 0);
    ret_model = '0;
    err_model = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    applyStimulus("r_after_reset", OP_R, 7'h00, 0, 0, 1'b1);
    tick();
    checkOutput("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
